// File: rtl/therm_pkg.sv
// Shared types and the saturating binary-to-thermometer encode used by the
// pair encoder and the downstream thermometer-to-binary stage.
package therm_pkg;

    localparam int THERM_N  = 4;
    localparam int THERM_BW = $clog2(THERM_N + 1);

    typedef enum logic [1:0] {
        EMPTY  = 2'd0,
        HOLD_A = 2'd1,
        FULL   = 2'd2
    } pair_state_t;

    typedef struct packed {
        logic                ovf;
        logic [THERM_N-1:0]  code;
    } therm_enc_t;

    // Low v bits set; values at or above THERM_N saturate to all ones and
    // values strictly above THERM_N also flag overflow.
    function automatic therm_enc_t bin2therm(input logic [THERM_BW-1:0] v);
        therm_enc_t res;
        res.ovf = (32'(v) > THERM_N);
        for (int i = 0; i < THERM_N; i++) begin
            res.code[i] = (32'(v) > i);
        end
        return res;
    endfunction

endpackage

// File: rtl/therm_pair_encoder.sv
// Encodes a stream of binary magnitudes to thermometer codes and pairs
// consecutive values into registered (a, b) operands for the compare stage.
module therm_pair_encoder
    import therm_pkg::*;
#(
    parameter int N  = THERM_N,
    parameter int BW = THERM_BW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [BW-1:0] in_data,
    output logic          pair_valid,
    input  logic          pair_ready,
    output logic [N-1:0]  a,
    output logic [N-1:0]  b,
    output logic          ovf
);

    pair_state_t state_reg, state_next;
    logic [N-1:0] a_reg, b_reg;
    logic         ovf_reg;
    logic         load_a, load_b;
    logic         in_fire, pair_fire;
    therm_enc_t   enc;

    // in_ready deliberately depends on pair_ready so a full pair can be
    // replaced by a new first operand on the same edge.
    assign pair_valid = (state_reg == FULL);
    assign in_ready   = !rst && !flush && ((state_reg != FULL) || pair_ready);
    assign in_fire    = in_valid && in_ready;
    assign pair_fire  = pair_valid && pair_ready;

    always_comb begin
        enc = bin2therm(in_data);
    end

    always_comb begin
        state_next = state_reg;
        load_a     = 1'b0;
        load_b     = 1'b0;
        if (flush) begin
            state_next = EMPTY;
        end else begin
            case (state_reg)
                EMPTY: begin
                    if (in_fire) begin
                        load_a     = 1'b1;
                        state_next = HOLD_A;
                    end
                end
                HOLD_A: begin
                    if (in_fire) begin
                        load_b     = 1'b1;
                        state_next = FULL;
                    end
                end
                FULL: begin
                    if (pair_fire && in_fire) begin
                        load_a     = 1'b1;
                        state_next = HOLD_A;
                    end else if (pair_fire) begin
                        state_next = EMPTY;
                    end
                end
                default: state_next = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= EMPTY;
            a_reg     <= '0;
            b_reg     <= '0;
            ovf_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (load_a) begin
                a_reg <= enc.code;
            end
            if (load_b) begin
                b_reg <= enc.code;
            end
            if (in_fire && enc.ovf) begin
                ovf_reg <= 1'b1;
            end
        end
    end

    assign a   = a_reg;
    assign b   = b_reg;
    assign ovf = ovf_reg;

endmodule
